// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue interface: push side from fetch, pop side to decode,
// plus flush and occupancy status. Exception encoding shared with the bench.
package fetch_queue_pkg;
    typedef enum logic [2:0] {
        NO_EXCEPTION          = 3'd0,
        INSTR_ADDR_MISALIGNED = 3'd1,
        INSTR_ACCESS_FAULT    = 3'd2,
        INSTR_PAGE_FAULT      = 3'd3,
        ILLEGAL_INSTR         = 3'd4
    } exc_type_e;
endpackage

interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    import fetch_queue_pkg::*;
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush_i;
    logic            push_valid_i;
    logic            push_ready_o;
    logic [XLEN-1:0] push_pc_i;
    logic [XLEN-1:0] push_inst_i;
    logic            push_is_comp_i;
    exc_type_e       push_exc_i;
    logic            push_taken_i;
    logic [XLEN-1:0] push_tgt_i;
    logic            pop_valid_o;
    logic            pop_ready_i;
    logic [XLEN-1:0] pop_pc_o;
    logic [XLEN-1:0] pop_inst_o;
    logic            pop_is_comp_o;
    exc_type_e       pop_exc_o;
    logic            pop_taken_o;
    logic [XLEN-1:0] pop_tgt_o;
    logic [CW-1:0]   count_o;
    logic            empty_o;
    logic            almost_full_o;

    modport master (
        output flush_i, push_valid_i, push_pc_i, push_inst_i, push_is_comp_i,
               push_exc_i, push_taken_i, push_tgt_i, pop_ready_i,
        input  push_ready_o, pop_valid_o, pop_pc_o, pop_inst_o, pop_is_comp_o,
               pop_exc_o, pop_taken_o, pop_tgt_o, count_o, empty_o, almost_full_o
    );

    modport slave (
        input  flush_i, push_valid_i, push_pc_i, push_inst_i, push_is_comp_i,
               push_exc_i, push_taken_i, push_tgt_i, pop_ready_i,
        output push_ready_o, pop_valid_o, pop_pc_o, pop_inst_o, pop_is_comp_o,
               pop_exc_o, pop_taken_o, pop_tgt_o, count_o, empty_o, almost_full_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with optional empty-queue
// bypass, occupancy status and an exception fence behind a faulting fetch.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int BYPASS   = 1,
    parameter int AFULL_TH = DEPTH - 1
) (
    input logic         clk_i,
    input logic         rst_i,
    fetch_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            is_comp;
        exc_type_e       exc;
        logic            taken;
        logic [XLEN-1:0] tgt;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          fence;

    entry_t push_ent, head;
    logic   push_ready, pop_valid, byp, byp_thru;
    logic   push_fire, pop_fire, wr_en, rd_en;

    always_comb begin
        push_ent         = '0;
        push_ent.pc      = q.push_pc_i;
        push_ent.inst    = q.push_inst_i;
        push_ent.is_comp = q.push_is_comp_i;
        push_ent.exc     = q.push_exc_i;
        push_ent.taken   = q.push_taken_i;
        push_ent.tgt     = q.push_tgt_i;
    end

    assign push_ready = !q.flush_i && (count < CW'(DEPTH)) && !fence;
    assign byp        = (BYPASS != 0) && (count == '0);

    always_comb begin
        if (byp) begin
            pop_valid = q.push_valid_i && push_ready;
            head      = push_ent;
        end else begin
            pop_valid = (count != '0) && !q.flush_i;
            head      = mem[rd_ptr];
        end
    end

    assign push_fire = q.push_valid_i && push_ready;
    assign pop_fire  = pop_valid && q.pop_ready_i;
    // An entry forwarded and consumed in the same cycle never touches storage.
    assign byp_thru  = byp && push_fire && q.pop_ready_i;
    assign wr_en     = push_fire && !byp_thru;
    assign rd_en     = pop_fire && !byp_thru;

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fence  <= 1'b0;
        end else if (q.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fence  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // With the fence up nothing else is accepted, so the faulting
            // entry is always the youngest and leaves when count drops to 0.
            if (wr_en && push_ent.exc != NO_EXCEPTION)
                fence <= 1'b1;
            else if (fence && rd_en && count == CW'(1))
                fence <= 1'b0;
        end
    end

    assign q.push_ready_o  = push_ready;
    assign q.pop_valid_o   = pop_valid;
    assign q.pop_pc_o      = pop_valid ? head.pc      : '0;
    assign q.pop_inst_o    = pop_valid ? head.inst    : '0;
    assign q.pop_is_comp_o = pop_valid ? head.is_comp : 1'b0;
    assign q.pop_exc_o     = pop_valid ? head.exc     : NO_EXCEPTION;
    assign q.pop_taken_o   = pop_valid ? head.taken   : 1'b0;
    assign q.pop_tgt_o     = pop_valid ? head.tgt     : '0;
    assign q.count_o       = count;
    assign q.empty_o       = (count == '0);
    assign q.almost_full_o = (count >= CW'(AFULL_TH));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench: a non-bypass (d0) and a bypass (d1) queue share one stimulus;
// a queue-based model is compared every cycle, plus literal spot checks.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        comp;
        exc_type_e   exc;
        logic        taken;
        logic [31:0] tgt;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0, pv = 1'b0, pr = 1'b0;
    ent_t pin = '0;
    int   tests = 0, fails = 0;

    ent_t q0[$], q1[$], mq[$];
    ent_t eh, ah;
    logic apv, apr, aemp, aaf, epv, epr, fen, byp, pf, pof;
    logic [2:0] acnt;
    int   n;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) i0 ();
    fetch_queue_if #(.XLEN(32), .DEPTH(4)) i1 ();

    fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(0), .AFULL_TH(3))
        dut0 (.clk_i(clk), .rst_i(rst), .q(i0.slave));
    fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(1), .AFULL_TH(3))
        dut1 (.clk_i(clk), .rst_i(rst), .q(i1.slave));

    always #5 clk = ~clk;

    assign i0.flush_i = flush;          assign i1.flush_i = flush;
    assign i0.push_valid_i = pv;        assign i1.push_valid_i = pv;
    assign i0.push_pc_i = pin.pc;       assign i1.push_pc_i = pin.pc;
    assign i0.push_inst_i = pin.inst;   assign i1.push_inst_i = pin.inst;
    assign i0.push_is_comp_i = pin.comp; assign i1.push_is_comp_i = pin.comp;
    assign i0.push_exc_i = pin.exc;     assign i1.push_exc_i = pin.exc;
    assign i0.push_taken_i = pin.taken; assign i1.push_taken_i = pin.taken;
    assign i0.push_tgt_i = pin.tgt;     assign i1.push_tgt_i = pin.tgt;
    assign i0.pop_ready_i = pr;         assign i1.pop_ready_i = pr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input exc_type_e e);
        pv        = 1'b1;
        pin.pc    = pc;
        pin.inst  = ~pc;
        pin.comp  = pc[2];
        pin.exc   = e;
        pin.taken = pc[3];
        pin.tgt   = pc + 32'h40;
    endtask

    // Model: a plain FIFO of entries; the fence is "a faulting entry is queued".
    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            mq = (b == 1) ? q1 : q0;
            if (rst) mq.delete();
            n   = mq.size();
            fen = 1'b0;
            foreach (mq[k]) if (mq[k].exc != NO_EXCEPTION) fen = 1'b1;
            epr = !flush && n < 4 && !fen;
            byp = (b == 1) && n == 0;
            if (byp) begin
                epv = pv && epr;
                eh  = pin;
            end else begin
                epv = n != 0 && !flush;
                eh  = (n != 0) ? mq[0] : '0;
            end
            if (!epv) eh = '0;
            if (b == 0) begin
                ah   = '{i0.pop_pc_o, i0.pop_inst_o, i0.pop_is_comp_o, i0.pop_exc_o,
                         i0.pop_taken_o, i0.pop_tgt_o};
                apv  = i0.pop_valid_o;  apr = i0.push_ready_o;  acnt = i0.count_o;
                aemp = i0.empty_o;      aaf = i0.almost_full_o;
            end else begin
                ah   = '{i1.pop_pc_o, i1.pop_inst_o, i1.pop_is_comp_o, i1.pop_exc_o,
                         i1.pop_taken_o, i1.pop_tgt_o};
                apv  = i1.pop_valid_o;  apr = i1.push_ready_o;  acnt = i1.count_o;
                aemp = i1.empty_o;      aaf = i1.almost_full_o;
            end
            chk($sformatf("d%0d push_ready", b), apr, epr);
            chk($sformatf("d%0d pop_valid", b), apv, epv);
            chk($sformatf("d%0d pop_pc", b), ah.pc, eh.pc);
            chk($sformatf("d%0d pop_inst", b), ah.inst, eh.inst);
            chk($sformatf("d%0d pop_tgt", b), ah.tgt, eh.tgt);
            chk($sformatf("d%0d pop_flags", b), {ah.comp, ah.exc, ah.taken},
                {eh.comp, eh.exc, eh.taken});
            chk($sformatf("d%0d count", b), acnt, n);
            chk($sformatf("d%0d empty", b), aemp, n == 0);
            chk($sformatf("d%0d almost_full", b), aaf, n >= 3);
            if (flush) mq.delete();
            else if (!rst) begin
                pf  = pv && epr;
                pof = epv && pr;
                if (!(byp && pf && pof)) begin
                    if (pof) void'(mq.pop_front());
                    if (pf) mq.push_back(pin);
                end
            end
            if (b == 1) q1 = mq; else q0 = mq;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset push_ready", i0.push_ready_o, 1);
        chk("reset pop_valid", i0.pop_valid_o, 0);
        chk("reset empty", i0.empty_o, 1);
        chk("reset count", i0.count_o, 0);
        rst = 1'b0;

        // fill then drain
        for (int i = 0; i < 4; i++) begin
            push(32'h100 + 32'(4 * i), NO_EXCEPTION);
            step();
            chk("fill count", i0.count_o, i + 1);
            chk("fill almost_full", i0.almost_full_o, i >= 2);
        end
        pv = 1'b0;
        chk("full count", i0.count_o, 4);
        chk("full push_ready", i0.push_ready_o, 0);
        pr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain pc", i0.pop_pc_o, 32'h100 + 32'(4 * i));
            step();
        end
        chk("drain empty", i0.empty_o, 1);
        pr = 1'b0;

        // same-cycle bypass
        pr = 1'b1;
        push(32'h200, NO_EXCEPTION);
        #1;
        chk("bypass pop_valid", i1.pop_valid_o, 1);
        chk("bypass pop_pc", i1.pop_pc_o, 32'h200);
        chk("nobypass pop_valid", i0.pop_valid_o, 0);
        step();
        pv = 1'b0;
        chk("bypass count", i1.count_o, 0);
        chk("nobypass count", i0.count_o, 1);
        step();
        chk("nobypass empty", i0.empty_o, 1);
        pr = 1'b0;

        // full with concurrent pop
        for (int i = 0; i < 4; i++) begin
            push(32'h500 + 32'(4 * i), NO_EXCEPTION);
            step();
        end
        push(32'h510, NO_EXCEPTION);
        pr = 1'b1;
        step();
        chk("full pop count", i0.count_o, 3);
        chk("full pop count d1", i1.count_o, 3);
        step();
        chk("push+pop count", i0.count_o, 3);
        pv = 1'b0;
        repeat (3) step();
        chk("full drain empty", i0.empty_o, 1);
        pr = 1'b0;

        // exception fence
        push(32'h300, NO_EXCEPTION);
        step();
        push(32'h304, INSTR_ACCESS_FAULT);
        step();
        chk("fence push_ready", i0.push_ready_o, 0);
        push(32'h308, NO_EXCEPTION);
        repeat (2) step();
        chk("fence hold count", i0.count_o, 2);
        pr = 1'b1;
        step();
        chk("fence after 1 pop", i0.push_ready_o, 0);
        step();
        chk("fence cleared", i0.push_ready_o, 1);
        chk("fence cleared count", i0.count_o, 0);
        pr = 1'b0;
        step();
        chk("post fence accept", i0.count_o, 1);
        pv = 1'b0;
        pr = 1'b1;
        step();
        chk("post fence empty", i0.empty_o, 1);

        // faulting entry consumed through bypass leaves no fence
        push(32'h600, INSTR_PAGE_FAULT);
        step();
        pv = 1'b0;
        chk("bypass fault no fence", i1.push_ready_o, 1);
        chk("stored fault fence", i0.push_ready_o, 0);
        step();
        chk("stored fault cleared", i0.push_ready_o, 1);
        pr = 1'b0;

        // flush mid-operation
        for (int i = 0; i < 3; i++) begin
            push(32'h700 + 32'(4 * i), NO_EXCEPTION);
            step();
        end
        chk("preflush count", i0.count_o, 3);
        push(32'h70C, NO_EXCEPTION);
        flush = 1'b1;
        #1;
        chk("flush pop_valid", i0.pop_valid_o, 0);
        chk("flush push_ready", i0.push_ready_o, 0);
        chk("flush pop_valid d1", i1.pop_valid_o, 0);
        step();
        flush = 1'b0;
        pv = 1'b0;
        chk("postflush count", i0.count_o, 0);
        chk("postflush pop_valid", i0.pop_valid_o, 0);
        push(32'h400, NO_EXCEPTION);
        step();
        pv = 1'b0;
        pr = 1'b1;
        chk("postflush first pc", i0.pop_pc_o, 32'h400);
        step();
        pr = 1'b0;

        // wrap: one push and one pop per cycle
        pr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(32'h800 + 32'(4 * i), NO_EXCEPTION);
            #1;
            chk("wrap bypass pc", i1.pop_pc_o, 32'h800 + 32'(4 * i));
            if (i > 0) chk("wrap pc", i0.pop_pc_o, 32'h800 + 32'(4 * (i - 1)));
            step();
        end
        pv = 1'b0;
        step();
        chk("wrap empty", i0.empty_o, 1);
        pr = 1'b0;

        // async reset mid-cycle
        push(32'h900, NO_EXCEPTION);
        step();
        push(32'h904, NO_EXCEPTION);
        step();
        pv = 1'b0;
        chk("prereset count", i0.count_o, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst count", i0.count_o, 0);
        chk("async rst empty", i0.empty_o, 1);
        chk("async rst push_ready", i0.push_ready_o, 1);
        chk("async rst pop_valid", i0.pop_valid_o, 0);
        chk("async rst pop_pc", i0.pop_pc_o, 0);
        chk("async rst almost_full", i0.almost_full_o, 0);
        step();
        rst = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
